// File: rtl/multicycle_control_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-timeout and illegal-opcode trap.
// Optional build macro CTRL_PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel_data,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic [1:0] alu_op,
    output logic       alu_src_imm,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       instr_retired,
    output logic       err,
    output logic [2:0] state_dbg
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd7
    } state_e;

    localparam logic [2:0] OP_LD  = 3'b000;
    localparam logic [2:0] OP_ST  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_hit;
    logic [1:0]      op_alu;
    logic            op_imm;

    assign to_hit    = (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
    assign state_dbg = state_q;

    // ALU controls implied by the latched opcode; beq compares by subtraction.
    always_comb begin
        op_imm = (op_q == OP_LD) || (op_q == OP_ST);
        unique case (op_q)
            OP_SUB, OP_BEQ: op_alu = 2'b01;
            OP_AND:         op_alu = 2'b10;
            OP_OR:          op_alu = 2'b11;
            default:        op_alu = 2'b00;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d       = state_q;
        op_d          = op_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_sel_data  = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = 1'b0;
        alu_op        = 2'b00;
        alu_src_imm   = 1'b0;
        reg_we        = 1'b0;
        wb_sel        = 1'b0;
        instr_retired = 1'b0;
        err           = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                op_d    = opcode;
                state_d = (opcode == OP_ILL) ? S_ERROR : S_EXEC;
            end
            S_EXEC: begin
                alu_op      = op_alu;
                alu_src_imm = op_imm;
                if (op_imm) begin
                    state_d = S_MEM;
                end else if (op_q == OP_BEQ) begin
                    pc_we         = zero;
                    pc_src        = zero;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = (op_q == OP_ST);
                alu_op       = op_alu;
                alu_src_imm  = op_imm;
                if (mem_ack) begin
                    instr_retired = (op_q == OP_ST);
                    state_d       = (op_q == OP_ST) ? S_FETCH : S_WB;
                end else if (to_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                reg_we        = 1'b1;
                wb_sel        = (op_q == OP_LD);
                alu_op        = op_alu;
                alu_src_imm   = op_imm;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            default: begin
                err     = 1'b1;
                state_d = S_ERROR;
            end
        endcase

        // Counter runs only while a request stays outstanding in the same state; any exit or ack clears it.
        to_cnt_d = (mem_req && !mem_ack && state_d == state_q) ? to_cnt_q + TO_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 3'b000;
            to_cnt_q <= '0;
`ifdef CTRL_PERF_CNT_EN
            cyc_cnt  <= '0;
            ret_cnt  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            to_cnt_q <= to_cnt_d;
`ifdef CTRL_PERF_CNT_EN
            if (state_q != S_IDLE && state_q != S_ERROR) cyc_cnt <= cyc_cnt + 32'd1;
            if (instr_retired)                           ret_cnt <= ret_cnt + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm; each step compares state and all control outputs.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ack;
    logic       mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src;
    logic [1:0] alu_op;
    logic       alu_src_imm, reg_we, wb_sel, instr_retired, err;
    logic [2:0] state_dbg;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_sel_data  (mem_sel_data),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .alu_src_imm   (alu_src_imm),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .instr_retired (instr_retired),
        .err           (err),
        .state_dbg     (state_dbg)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cyc_cnt       (cyc_cnt),
        .ret_cnt       (ret_cnt)
`endif
    );

    // ctl layout: {req,we,sel}_{ir_we,pc_we,pc_src}_{alu_op}_{imm,reg_we,wb_sel}_{retired,err}
    localparam logic [12:0] C_NONE    = 13'b000_000_00_000_00;
    localparam logic [12:0] C_FETCH   = 13'b100_000_00_000_00;
    localparam logic [12:0] C_FET_ACK = 13'b100_110_00_000_00;
    localparam logic [12:0] C_EXEC_LS = 13'b000_000_00_100_00;
    localparam logic [12:0] C_MEM_LD  = 13'b101_000_00_100_00;
    localparam logic [12:0] C_ERR     = 13'b000_000_00_000_01;

    task automatic expect_o(input string tag, input logic [2:0] st, input logic [12:0] ctl);
        logic [15:0] obs;
        logic [15:0] exp;
        #1;
        obs = {state_dbg, mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, alu_op,
               alu_src_imm, reg_we, wb_sel, instr_retired, err};
        exp = {st, ctl};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed {st,ctl}=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: acknowledged fetch, then DECODE latching op.
    task automatic fetch_decode(input logic [2:0] op);
        mem_ack = 1'b1;
        opcode  = op;
        expect_o("fetch_ack", 3'd1, C_FET_ACK);
        step();
        mem_ack = 1'b0;
        expect_o("decode", 3'd2, C_NONE);
        step();
    endtask

    // R-type from EXEC: opcode input is corrupted and ack pulsed to prove both are ignored there.
    task automatic run_rtype(input string tag, input logic [1:0] aop);
        opcode  = 3'b111;
        mem_ack = 1'b1;
        expect_o({tag, "_exec"}, 3'd3, {8'b000_000_00 | 8'(aop), 5'b000_00});
        step();
        mem_ack = 1'b0;
        expect_o({tag, "_wb"}, 3'd5, {6'b000_000, aop, 5'b010_10});
        step();
        expect_o({tag, "_back_fetch"}, 3'd1, C_FETCH);
    endtask

    initial begin
        rst_n   = 1'b0;
        opcode  = 3'b000;
        zero    = 1'b0;
        mem_ack = 1'b0;
        expect_o("reset_state", 3'd0, C_NONE);
        repeat (2) step();
        rst_n = 1'b1;
        expect_o("idle_after_release", 3'd0, C_NONE);
        step();
        expect_o("first_fetch", 3'd1, C_FETCH);

        // add with immediate ack, then the other R-types
        fetch_decode(3'b010);
        run_rtype("add", 2'b00);
        fetch_decode(3'b011);
        run_rtype("sub", 2'b01);
        fetch_decode(3'b100);
        run_rtype("and", 2'b10);
        fetch_decode(3'b101);
        run_rtype("or", 2'b11);

        // ld with data ack on the 4th MEM cycle
        fetch_decode(3'b000);
        expect_o("ld_exec", 3'd3, C_EXEC_LS);
        step();
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            expect_o("ld_mem_wait", 3'd4, C_MEM_LD);
            step();
        end
        mem_ack = 1'b0;
        expect_o("ld_wb", 3'd5, 13'b000_000_00_111_10);
        step();
        expect_o("ld_back_fetch", 3'd1, C_FETCH);

        // st: write access, retire on ack, no reg_we anywhere
        fetch_decode(3'b001);
        expect_o("st_exec", 3'd3, C_EXEC_LS);
        step();
        expect_o("st_mem_wait", 3'd4, 13'b111_000_00_100_00);
        mem_ack = 1'b1;
        expect_o("st_mem_ack", 3'd4, 13'b111_000_00_100_10);
        step();
        mem_ack = 1'b0;
        expect_o("st_back_fetch", 3'd1, C_FETCH);

        // beq taken and not taken
        fetch_decode(3'b110);
        zero = 1'b1;
        expect_o("beq_taken", 3'd3, 13'b000_011_01_000_10);
        step();
        expect_o("beq_taken_fetch", 3'd1, C_FETCH);
        fetch_decode(3'b110);
        zero = 1'b0;
        expect_o("beq_not_taken", 3'd3, 13'b000_000_01_000_10);
        step();
        expect_o("beq_nt_fetch", 3'd1, C_FETCH);

        // asynchronous reset in the middle of a MEM access
        fetch_decode(3'b000);
        step();
        expect_o("pre_reset_mem", 3'd4, C_MEM_LD);
        rst_n = 1'b0;
        expect_o("reset_mid_mem", 3'd0, C_NONE);
        step();
        rst_n = 1'b1;
        expect_o("idle_after_mid_reset", 3'd0, C_NONE);
        step();
        expect_o("fetch_after_mid_reset", 3'd1, C_FETCH);

        // ack arriving exactly at the timeout limit (16th FETCH cycle) wins
        for (int i = 0; i < 15; i++) step();
        expect_o("fetch_cycle16", 3'd1, C_FETCH);
        fetch_decode(3'b010);
        run_rtype("add_after_limit_ack", 2'b00);

        // illegal opcode trap, sticky against ack
        mem_ack = 1'b1;
        opcode  = 3'b111;
        expect_o("fetch_ack_ill", 3'd1, C_FET_ACK);
        step();
        mem_ack = 1'b0;
        expect_o("decode_ill", 3'd2, C_NONE);
        step();
        expect_o("illegal_error", 3'd7, C_ERR);
        mem_ack = 1'b1;
        opcode  = 3'b010;
        repeat (3) step();
        expect_o("error_sticky", 3'd7, C_ERR);

        // FETCH timeout: 16 unacknowledged cycles, then ERROR
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 15) expect_o("fetch_no_ack", 3'd1, C_FETCH);
            step();
        end
        expect_o("fetch_timeout_error", 3'd7, C_ERR);
        step();
        expect_o("timeout_error_held", 3'd7, C_ERR);

        // MEM timeout for a load that never gets data
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        fetch_decode(3'b000);
        step();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect_o("mem_last_wait", 3'd4, C_MEM_LD);
            step();
        end
        expect_o("mem_timeout_error", 3'd7, C_ERR);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
